// File: rtl/pht_predictor.sv
// Pattern history table of 2-bit saturating counters with a two-stage update path and statistics.
// Optional macro PHT_BYPASS_EN forwards the in-flight write to a same-index lookup.
`timescale 1ns/1ps
module pht_predictor #(
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       lookup_index,
  output logic             predict_taken,
  output logic [1:0]       predict_state,
  input  logic             upd_valid,
  input  logic [3:0]       upd_index,
  input  logic             upd_taken,
  input  logic             upd_predicted,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  // upd_valid is a one-cycle qualifier with no back-pressure: every cycle it is
  // high carries exactly one resolved branch, and the predictor always accepts it.

  logic [1:0]       pht_q [16];
  logic             pend_valid_q;
  logic [3:0]       pend_index_q;
  logic             pend_taken_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispred_count_q;

  logic [1:0]       wr_old;
  logic [1:0]       wr_new;
  logic [1:0]       lookup_raw;
  logic             upd_mispred;

  // Stage-2 write value is derived from the live array entry, so consecutive
  // updates to one index chain through the array without forwarding.
  always_comb begin
    wr_old = pht_q[pend_index_q];
    wr_new = wr_old;
    if (pend_taken_q) begin
      if (wr_old != 2'b11) wr_new = wr_old + 2'd1;
    end else begin
      if (wr_old != 2'b00) wr_new = wr_old - 2'd1;
    end
  end

  always_comb begin
    lookup_raw    = pht_q[lookup_index];
`ifdef PHT_BYPASS_EN
    predict_state = (pend_valid_q && (lookup_index == pend_index_q)) ? wr_new : lookup_raw;
`else
    predict_state = lookup_raw;
`endif
    predict_taken = predict_state[1];
  end

  assign upd_mispred = upd_valid && (upd_taken != upd_predicted);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pht_q[i] <= INIT_STATE;
      pend_valid_q    <= 1'b0;
      pend_index_q    <= 4'd0;
      pend_taken_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      if (pend_valid_q) pht_q[pend_index_q] <= wr_new;
      pend_valid_q <= upd_valid;
      if (upd_valid) begin
        pend_index_q <= upd_index;
        pend_taken_q <= upd_taken;
      end
      mispredict_q <= upd_mispred;
      // Statistics stick at all-ones instead of wrapping.
      if (upd_valid && (branch_count_q != '1))
        branch_count_q <= branch_count_q + CNT_W'(1);
      if (upd_mispred && (mispred_count_q != '1))
        mispred_count_q <= mispred_count_q + CNT_W'(1);
    end
  end

  assign mispredict    = mispredict_q;
  assign branch_count  = branch_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Self-checking bench for pht_predictor: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  lookup_index;
  logic        predict_taken;
  logic [1:0]  predict_state;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        upd_predicted;
  logic        mispredict;
  logic [15:0] branch_count;
  logic [15:0] mispred_count;

  int errors = 0;
  int checks = 0;

  pht_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_index  (lookup_index),
    .predict_taken (predict_taken),
    .predict_state (predict_state),
    .upd_valid     (upd_valid),
    .upd_index     (upd_index),
    .upd_taken     (upd_taken),
    .upd_predicted (upd_predicted),
    .mispredict    (mispredict),
    .branch_count  (branch_count),
    .mispred_count (mispred_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Array contents, resolved updates still in flight, and statistics.
  typedef struct { int idx; bit taken; } upd_t;
  int   m_pht [16];
  upd_t inflight_q[$];
  int   m_branch;
  int   m_mispred;
  bit   m_mispredict;

  function automatic int sat_step(int v, bit t);
    if (t) return (v == 3) ? 3 : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic int exp_lookup(int look);
    int v;
    v = m_pht[look];
`ifdef PHT_BYPASS_EN
    if (inflight_q.size() > 0 && inflight_q[0].idx == look) v = sat_step(v, inflight_q[0].taken);
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    inflight_q.delete();
    m_branch     = 0;
    m_mispred    = 0;
    m_mispredict = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, advance through the rising edge, return 1ns after it.
  task automatic apply(bit v, int idx, bit t, bit p, int look);
    upd_t u;
    upd_valid     = v;
    upd_index     = idx[3:0];
    upd_taken     = t;
    upd_predicted = p;
    lookup_index  = look[3:0];
    @(posedge clk);
    if (inflight_q.size() > 0) begin
      u = inflight_q.pop_front();
      m_pht[u.idx] = sat_step(m_pht[u.idx], u.taken);
    end
    m_mispredict = v && (t != p);
    if (v) begin
      u.idx = idx; u.taken = t;
      inflight_q.push_back(u);
      if (m_branch < 65535) m_branch++;
      if (t != p && m_mispred < 65535) m_mispred++;
    end
    #1;
  endtask

  task automatic do_reset();
    upd_valid = 0; upd_index = 0; upd_taken = 0; upd_predicted = 0; lookup_index = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    checks++;
    if (branch_count !== 16'd0) begin errors++; $display("FAIL reset_branch_count got=%0d exp=0", branch_count); end
    checks++;
    if (mispred_count !== 16'd0) begin errors++; $display("FAIL reset_mispred_count got=%0d exp=0", mispred_count); end
    checks++;
    for (int i = 0; i < 16; i++) begin
      lookup_index = i[3:0];
      #1;
      if (predict_state !== 2'b01 || predict_taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_sweep idx=%0d got=%b/%b exp=01/0", i, predict_state, predict_taken);
      end
      checks++;
    end
  endtask

  task automatic test_saturate_taken();
    logic [1:0] exp_state [3];
    do_reset();
    exp_state[0] = 2'b01; exp_state[1] = 2'b10; exp_state[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      apply(1, 5, 1, 0, 5);
      if (mispredict !== 1'b1) begin errors++; $display("FAIL sat_taken_mispredict k=%0d got=%b exp=1", k, mispredict); end
      checks++;
`ifndef PHT_BYPASS_EN
      if (predict_state !== exp_state[k]) begin
        errors++; $display("FAIL sat_taken_raw k=%0d got=%b exp=%b", k, predict_state, exp_state[k]);
      end
      checks++;
`endif
    end
    apply(0, 0, 0, 0, 5);
    if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_taken_pulse_end got=%b exp=0", mispredict); end
    checks++;
    apply(0, 0, 0, 0, 5);
    if (predict_state !== 2'b11) begin errors++; $display("FAIL sat_taken_final got=%b exp=11", predict_state); end
    checks++;
    if (branch_count !== 16'd3 || mispred_count !== 16'd3) begin
      errors++; $display("FAIL sat_taken_counts got=%0d/%0d exp=3/3", branch_count, mispred_count);
    end
    checks++;
  endtask

  task automatic test_saturate_not_taken();
    do_reset();
    for (int k = 0; k < 4; k++) apply(1, 9, 0, 0, 9);
    if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_nt_mispredict got=%b exp=0", mispredict); end
    checks++;
    apply(0, 0, 0, 0, 9);
    apply(0, 0, 0, 0, 9);
    if (predict_state !== 2'b00) begin errors++; $display("FAIL sat_nt_final got=%b exp=00", predict_state); end
    checks++;
    if (branch_count !== 16'd4 || mispred_count !== 16'd0) begin
      errors++; $display("FAIL sat_nt_counts got=%0d/%0d exp=4/0", branch_count, mispred_count);
    end
    checks++;
  endtask

  task automatic test_bypass();
    logic [1:0] exp_pend;
    do_reset();
`ifdef PHT_BYPASS_EN
    exp_pend = 2'b10;
`else
    exp_pend = 2'b01;
`endif
    apply(1, 3, 1, 1, 3);
    if (predict_state !== exp_pend) begin errors++; $display("FAIL bypass_pend_cycle got=%b exp=%b", predict_state, exp_pend); end
    checks++;
    apply(0, 0, 0, 0, 3);
    if (predict_state !== 2'b10 || predict_taken !== 1'b1) begin
      errors++; $display("FAIL bypass_next_cycle got=%b/%b exp=10/1", predict_state, predict_taken);
    end
    checks++;
  endtask

  task automatic test_reset_mid_update();
    do_reset();
    apply(1, 7, 1, 0, 7);
    if (mispredict !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", mispredict); end
    checks++;
    rst = 1'b1;
    model_reset();
    #1;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b exp=0", mispredict); end
    checks++;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(0, 0, 0, 0, 7);
    apply(0, 0, 0, 0, 7);
    if (predict_state !== 2'b01 || mispredict !== 1'b0) begin
      errors++; $display("FAIL midrst_discard got=%b/%b exp=01/0", predict_state, mispredict);
    end
    checks++;
    // First update after release is processed normally.
    apply(1, 2, 0, 0, 2);
    apply(0, 0, 0, 0, 2);
    if (predict_state !== 2'b00 || branch_count !== 16'd1) begin
      errors++; $display("FAIL midrst_first_update got=%b/%0d exp=00/1", predict_state, branch_count);
    end
    checks++;
  endtask

  task automatic test_random();
    int v, idx, t, p, look;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 3) != 0;
      idx = $urandom_range(0, 3);          // narrow range makes same-index collisions frequent
      t = $urandom_range(0, 1);
      p = $urandom_range(0, 1);
      look = ($urandom_range(0, 1) != 0 && inflight_q.size() > 0) ? inflight_q[0].idx : $urandom_range(0, 15);
      apply(v[0], idx, t[0], p[0], look);
      // Lookup may target a different index than the one just driven; settle it first.
      lookup_index = look[3:0];
      #1;
      if (predict_state !== 2'(exp_lookup(look)) || predict_taken !== exp_lookup(look) / 2) begin
        errors++; $display("FAIL rand_lookup n=%0d idx=%0d got=%b exp=%0d", n, look, predict_state, exp_lookup(look));
      end
      checks++;
      if (mispredict !== m_mispredict) begin
        errors++; $display("FAIL rand_mispredict n=%0d got=%b exp=%b", n, mispredict, m_mispredict);
      end
      checks++;
      if (branch_count !== 16'(m_branch) || mispred_count !== 16'(m_mispred)) begin
        errors++; $display("FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, branch_count, mispred_count, m_branch, m_mispred);
      end
      checks++;
    end
  endtask

  task automatic test_count_saturation();
    int t;
    do_reset();
    for (int n = 0; n < 65534; n++) begin
      t = $urandom_range(0, 1);
      apply(1, $urandom_range(0, 15), t[0], ~t[0], 0);
    end
    if (branch_count !== 16'hFFFE || mispred_count !== 16'hFFFE) begin
      errors++; $display("FAIL cnt_pre_sat got=%h/%h exp=fffe/fffe", branch_count, mispred_count);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      apply(1, k, 1, 0, k);
      if (branch_count !== 16'hFFFF || mispred_count !== 16'hFFFF) begin
        errors++; $display("FAIL cnt_sat k=%0d got=%h/%h exp=ffff/ffff", k, branch_count, mispred_count);
      end
      checks++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    upd_valid = 0; upd_index = 0; upd_taken = 0; upd_predicted = 0; lookup_index = 0;
    test_reset();
    test_saturate_taken();
    test_saturate_not_taken();
    test_bypass();
    test_reset_mid_update();
    test_random();
    test_count_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
